// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: word type, default FIFO depth and
// the index-width helper used to size FIFO pointers.
package spi_master_pkg;

  localparam int unsigned SPI_BUFFER_DEPTH = 32;

  typedef logic [31:0] spi_word_t;

  // Smallest r with 2**r >= value; never below 1 so a pointer always has a bit.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_master_fifo.sv
// Valid/ready word FIFO between the SPI APB register block and the shift
// controller; any depth >= 2, registered flags, no fall-through or full-bypass.
module spi_master_fifo
  import spi_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned BUFFER_DEPTH     = SPI_BUFFER_DEPTH,
  parameter int unsigned LOG_BUFFER_DEPTH = log2(BUFFER_DEPTH)
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic                        clr_i,
  output logic [LOG_BUFFER_DEPTH:0]   elements_o,
  input  logic [DATA_WIDTH-1:0]       data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        valid_o,
  input  logic                        ready_i
);

  localparam logic [LOG_BUFFER_DEPTH-1:0] LAST_IDX = LOG_BUFFER_DEPTH'(BUFFER_DEPTH - 1);
  localparam logic [LOG_BUFFER_DEPTH:0]   FULL_CNT = (LOG_BUFFER_DEPTH + 1)'(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0]       r_mem [BUFFER_DEPTH];
  logic [LOG_BUFFER_DEPTH-1:0] r_wr_ptr;
  logic [LOG_BUFFER_DEPTH-1:0] r_rd_ptr;
  logic [LOG_BUFFER_DEPTH:0]   r_cnt;

  logic w_ready;
  logic w_valid;
  logic w_push;
  logic w_pop;

  // Explicit wrap at the last entry so non-power-of-two depths work.
  function automatic logic [LOG_BUFFER_DEPTH-1:0] ptr_inc(input logic [LOG_BUFFER_DEPTH-1:0] ptr);
    if (ptr == LAST_IDX) return '0;
    return ptr + 1'b1;
  endfunction

  always_comb begin
    w_ready = (r_cnt != FULL_CNT);
    w_valid = (r_cnt != '0);
    w_push  = valid_i & w_ready;
    w_pop   = w_valid & ready_i;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (clr_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage resets to zero so data_o is defined out of reset; clear leaves it alone.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int unsigned i = 0; i < BUFFER_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !clr_i) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  assign ready_o    = w_ready;
  assign valid_o    = w_valid;
  assign elements_o = r_cnt;
  assign data_o     = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed self-checking bench: a depth-32 FIFO for fill/drain, streaming,
// clear and async reset, and a depth-5 FIFO for pointer wrap-around.
module tb_spi_master_fifo;

  logic        HCLK;
  logic        HRESETn;

  logic        a_clr, a_valid_i, a_ready_i, a_ready_o, a_valid_o;
  logic [31:0] a_data_i, a_data_o;
  logic [5:0]  a_elements;

  logic        b_clr, b_valid_i, b_ready_i, b_ready_o, b_valid_o;
  logic [31:0] b_data_i, b_data_o;
  logic [3:0]  b_elements;

  int checks;
  int failures;

  spi_master_fifo #(.DATA_WIDTH(32), .BUFFER_DEPTH(32)) u_fifo32 (
    .HCLK(HCLK), .HRESETn(HRESETn), .clr_i(a_clr), .elements_o(a_elements),
    .data_i(a_data_i), .valid_i(a_valid_i), .ready_o(a_ready_o),
    .data_o(a_data_o), .valid_o(a_valid_o), .ready_i(a_ready_i)
  );

  spi_master_fifo #(.DATA_WIDTH(32), .BUFFER_DEPTH(5)) u_fifo5 (
    .HCLK(HCLK), .HRESETn(HRESETn), .clr_i(b_clr), .elements_o(b_elements),
    .data_i(b_data_i), .valid_i(b_valid_i), .ready_o(b_ready_o),
    .data_o(b_data_o), .valid_o(b_valid_o), .ready_i(b_ready_i)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    HRESETn = 1'b0;
    a_clr = 0; a_valid_i = 0; a_ready_i = 0; a_data_i = '0;
    b_clr = 0; b_valid_i = 0; b_ready_i = 0; b_data_i = '0;
    #3;
    chk("rst_elements", 32'(a_elements), 32'd0);
    chk("rst_valid",    32'(a_valid_o),  32'd0);
    chk("rst_ready",    32'(a_ready_o),  32'd1);
    chk("rst_data",     a_data_o,        32'h0);
    #9 HRESETn = 1'b1;
    tick();

    // Fill to full with consumer stalled
    for (int i = 0; i < 32; i++) begin
      a_valid_i = 1; a_data_i = 32'(i);
      tick();
    end
    chk("full_elements", 32'(a_elements), 32'd32);
    chk("full_ready",    32'(a_ready_o),  32'd0);
    chk("full_head",     a_data_o,        32'h0);
    a_data_i = 32'hDEADBEEF;
    tick();
    chk("overflow_refused", 32'(a_elements), 32'd32);

    a_valid_i = 0; a_ready_i = 1;
    for (int i = 0; i < 32; i++) begin
      chk("drain_valid", 32'(a_valid_o), 32'd1);
      chk("drain_data",  a_data_o,       32'(i));
      tick();
    end
    chk("drained_valid",    32'(a_valid_o),  32'd0);
    chk("drained_elements", 32'(a_elements), 32'd0);
    chk("drained_ready",    32'(a_ready_o),  32'd1);

    // Empty: ready_i ignored, no fall-through on first push
    a_valid_i = 1; a_ready_i = 1; a_data_i = 32'h77;
    chk("empty_no_valid", 32'(a_valid_o), 32'd0);
    tick();
    chk("first_push_valid", 32'(a_valid_o),  32'd1);
    chk("first_push_data",  a_data_o,        32'h77);
    chk("first_push_count", 32'(a_elements), 32'd1);
    a_valid_i = 0;
    tick();
    chk("pop_single", 32'(a_elements), 32'd0);

    // Preload 5, then 100 cycles of simultaneous push/pop
    a_ready_i = 0; a_valid_i = 1;
    for (int i = 0; i < 5; i++) begin
      a_data_i = 32'(100 + i);
      tick();
    end
    a_ready_i = 1;
    for (int k = 0; k < 100; k++) begin
      a_data_i = 32'(105 + k);
      chk("stream_head", a_data_o, 32'(100 + k));
      tick();
      chk("stream_count", 32'(a_elements), 32'd5);
    end

    // Top up to full, then push+pop together: only the pop happens
    a_ready_i = 0;
    for (int i = 0; i < 27; i++) begin
      a_data_i = 32'(205 + i);
      tick();
    end
    chk("refill_count", 32'(a_elements), 32'd32);
    chk("refill_head",  a_data_o,        32'd200);
    a_ready_i = 1; a_data_i = 32'hBAD0BAD0;
    tick();
    chk("full_pushpop_count", 32'(a_elements), 32'd31);
    chk("full_pushpop_ready", 32'(a_ready_o),  32'd1);
    chk("full_pushpop_head",  a_data_o,        32'd201);

    // Clear with count 7 while pushing
    a_valid_i = 0; a_ready_i = 0; a_clr = 1;
    tick();
    a_clr = 0; a_valid_i = 1;
    for (int i = 0; i < 7; i++) begin
      a_data_i = 32'(300 + i);
      tick();
    end
    chk("preclr_count", 32'(a_elements), 32'd7);
    a_clr = 1; a_data_i = 32'hA5A5A5A5;
    tick();
    chk("clr_count", 32'(a_elements), 32'd0);
    chk("clr_valid", 32'(a_valid_o),  32'd0);
    a_clr = 0; a_data_i = 32'h12345678;
    tick();
    chk("post_clr_valid", 32'(a_valid_o),  32'd1);
    chk("post_clr_head",  a_data_o,        32'h12345678);
    chk("post_clr_count", 32'(a_elements), 32'd1);
    a_valid_i = 0; a_ready_i = 1;
    tick();
    chk("post_clr_pop", 32'(a_elements), 32'd0);

    // Async reset mid-stream at count 10
    a_ready_i = 0; a_valid_i = 1;
    for (int i = 0; i < 10; i++) begin
      a_data_i = 32'(32'h200 + i);
      tick();
    end
    a_valid_i = 0;
    chk("prerst_count", 32'(a_elements), 32'd10);
    #2 HRESETn = 1'b0;
    #1;
    chk("arst_elements", 32'(a_elements), 32'd0);
    chk("arst_valid",    32'(a_valid_o),  32'd0);
    chk("arst_ready",    32'(a_ready_o),  32'd1);
    chk("arst_data",     a_data_o,        32'h0);
    #2 HRESETn = 1'b1;
    a_valid_i = 1; a_data_i = 32'hCAFE0001;
    tick();
    a_valid_i = 0;
    chk("after_rst_valid", 32'(a_valid_o),  32'd1);
    chk("after_rst_head",  a_data_o,        32'hCAFE0001);
    chk("after_rst_count", 32'(a_elements), 32'd1);

    // Depth-5 wrap: occupancy 3, 17 push/pop cycles, then drain
    b_valid_i = 1; b_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      b_data_i = 32'(32'h50 + i);
      tick();
    end
    chk("d5_fill_count", 32'(b_elements), 32'd3);
    b_ready_i = 1;
    for (int k = 0; k < 17; k++) begin
      b_data_i = 32'(32'h53 + k);
      chk("d5_wrap_head", b_data_o, 32'(32'h50 + k));
      tick();
      chk("d5_wrap_count", 32'(b_elements), 32'd3);
    end
    b_valid_i = 0;
    for (int k = 17; k < 20; k++) begin
      chk("d5_drain_data", b_data_o, 32'(32'h50 + k));
      tick();
    end
    chk("d5_empty_valid", 32'(b_valid_o),  32'd0);
    chk("d5_empty_count", 32'(b_elements), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_fifo.md
# spi_master_fifo

Synchronous FIFO that buffers 32-bit words between the SPI master's APB register interface and its shift controller. One instance sits on the TX path: it absorbs `spi_data_tx`/`spi_data_tx_valid` writes and returns `spi_data_tx_ready`. A second instance sits on the RX path: it feeds `spi_data_rx`/`spi_data_rx_valid` and takes `spi_data_rx_ready` from the register interface. Both sides use valid/ready handshakes, and a live element count drives the threshold interrupt logic.

## Interface
- `DATA_WIDTH`, 32, word width.
- `BUFFER_DEPTH`, 32, number of entries; any value ≥ 2, not necessarily a power of two.
- `LOG_BUFFER_DEPTH`, log2(BUFFER_DEPTH), index width; the count is `LOG_BUFFER_DEPTH+1` bits.
- `HCLK`  in  1  clock.
- `HRESETn`  in  1  reset, asynchronous, active-low.
- `clr_i`  in  1  synchronous clear; on the TX path it is driven by `spi_swrst`.
- `elements_o`  out  `LOG_BUFFER_DEPTH+1`  current occupancy, 0..BUFFER_DEPTH.
- `data_i`  in  DATA_WIDTH  write data.
- `valid_i`  in  1  write request.
- `ready_o`  out  1  space available.
- `data_o`  out  DATA_WIDTH  head-of-queue data.
- `valid_o`  out  1  head data valid.
- `ready_i`  in  1  consumer accepts head.

## Operation
- State: storage array `mem[BUFFER_DEPTH]`, `wr_ptr`/`rd_ptr` of width `LOG_BUFFER_DEPTH`, and counter `cnt` of width `LOG_BUFFER_DEPTH+1`.
- Flags: `ready_o = (cnt != BUFFER_DEPTH)` and `valid_o = (cnt != 0)`. Both are combinational from registered state only; neither depends on `valid_i` or `ready_i`.
- Handshakes: push = `valid_i & ready_o`; pop = `valid_o & ready_i`.
- Push: `mem[wr_ptr] <= data_i`, and `wr_ptr` advances.
- Pop: `rd_ptr` advances.
- `data_o = mem[rd_ptr]`, read combinationally.
- Count update:
  - push only: +1
  - pop only: −1
  - both or neither: unchanged
- Pointer wrap: when a pointer equals `BUFFER_DEPTH-1` and advances, it goes to 0. It never uses a modulo-2^n wrap.
- `elements_o = cnt`.
- Full: `ready_o = 0`. Any write is refused, even if a pop occurs in the same cycle; there is no full-bypass. The refused word is not stored and the producer must hold it.
- Empty: `valid_o = 0` and `ready_i` is ignored. There is no fall-through: a word pushed into an empty FIFO is visible on `valid_o` the next cycle.
- Simultaneous push and pop with `0 < cnt < DEPTH`: both pointers advance, the count is unchanged, and the head updates to the next entry.
- `clr_i = 1`: `wr_ptr`, `rd_ptr` and `cnt` go to 0 on the next edge. Clear overrides any push or pop in the same cycle, so the pushed word is discarded. Memory contents are untouched.
- Asserting `HRESETn` mid-operation: all state is cleared immediately, with no completion of an in-flight handshake.

## Timing
- Reset values:
  - `elements_o = 0`
  - `valid_o = 0`
  - `ready_o = 1`
  - `data_o = 0` (memory is asynchronously reset to zero)
- Write-to-read latency: 1 cycle. A push at edge N makes `valid_o` high after edge N.
- Flag update: `elements_o`, `ready_o` and `valid_o` reflect the handshakes of edge N immediately after edge N.
- Throughput: one push and one pop per cycle, sustained at any occupancy except full (no push) or empty (no pop).
- Clear recovery: after a `clr_i` pulse at edge N, a push is accepted at edge N+1.
- Paths: there are no combinational paths from `valid_i` to `valid_o`, from `ready_i` to `ready_o`, or from `data_i` to `data_o`.

## Structure
- Shared package `spi_master_pkg`:
  - the `log2` function (replacing the macro)
  - the default `BUFFER_DEPTH`
  - the `spi_word_t` typedef (`logic [31:0]`)
- The block is a single module with no sub-modules. Pointer-increment-with-wrap is a local function.
- Instantiation: twice in the SPI master top. TX: APB interface → fifo → controller. RX: controller → fifo → APB interface.

## Test plan
- Reset: release `HRESETn` → `elements_o = 0`, `valid_o = 0`, `ready_o = 1`, `data_o = 0`.
- Fill and drain, depth 32:
  - push 0x00000000..0x0000001F with `ready_i = 0` → `elements_o = 32`, `ready_o = 0`.
  - then a 33rd push of 0xDEADBEEF → refused.
  - then drain → words pop in order 0x00..0x1F, followed by `valid_o = 0`.
- Simultaneous traffic:
  - set `cnt = 5`, then assert push and pop together for 100 cycles with incrementing data → `elements_o` stays 5 and output order is preserved.
  - with `cnt = 32`, assert push and pop together → only the pop occurs and `elements_o = 31`.
- Wrap-around with `BUFFER_DEPTH = 5`: 17 push/pop cycles at occupancy 3 → data integrity holds and pointers pass through 4→0 without corruption.
- Clear:
  - with `cnt = 7`, pulse `clr_i` together with a push of 0xA5A5A5A5 → the next cycle shows `elements_o = 0` and `valid_o = 0`.
  - the following push of 0x12345678 becomes the head one cycle later.
- Async reset mid-stream: with `cnt = 10`, assert `HRESETn` low between edges → outputs return to reset values immediately, and after release the first pushed word is the head.
